// File: rtl/snes_pad_poller_pkg.sv
// Shared types and constants for the SNES pad poller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package snes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_DONE
  } state_t;

  // Bits per pad report and length of the latch pulse in prescaler ticks.
  localparam int PAD_W       = 16;
  localparam int LATCH_TICKS = 2;

  // Clocks per snes_clock half-period, rounded down, never below 1.
  function automatic int calc_tick_div(input longint freq_hz, input longint half_us);
    longint d;
    d = (freq_hz * half_us) / 64'd1_000_000;
    return (d < 1) ? 1 : int'(d);
  endfunction

  // Clocks between automatic scans, never below 1.
  function automatic int calc_poll_div(input longint freq_hz, input longint poll_hz);
    longint d;
    d = freq_hz / poll_hz;
    return (d < 1) ? 1 : int'(d);
  endfunction

endpackage

// File: rtl/snes_pad_poller_if.sv
// Pad-side and host-side signal bundle of the SNES pad poller.
// Latency: n/a (wiring only).
// Backpressure: none; the host sees results through sample_valid pulses.
interface snes_pad_poller_if #(
  parameter int NUM_PADS = 2
);
  import snes_pad_pkg::*;

  // pad side
  logic                      snes_clock;
  logic                      snes_latch;
  logic [NUM_PADS-1:0]       pad_data;
  // host side
  logic [PAD_W*NUM_PADS-1:0] joy_data;
  logic                      sample_valid;
  logic                      busy;
  logic                      poll_now;
  logic [NUM_PADS-1:0]       irq_mask;
  logic                      irq;
  logic                      irq_ack;

  modport master (
    output snes_clock, snes_latch, joy_data, sample_valid, busy, irq,
    input  pad_data, poll_now, irq_mask, irq_ack
  );

  modport slave (
    input  snes_clock, snes_latch, joy_data, sample_valid, busy, irq,
    output pad_data, poll_now, irq_mask, irq_ack
  );

endinterface

// File: rtl/snes_pad_poller_tick_div.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV clocks after clear drops.
// Backpressure: none; clear holds the count at zero.
module snes_tick_div #(
  parameter int TICK_DIV = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = w_last;

  // Count 0..TICK_DIV-1 and wrap; clear restarts the period from zero.
  always_ff @(posedge clock) begin
    if (!reset_n || i_clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snes_pad_poller.sv
// Periodically scans up to four SNES pads and publishes 16-bit words per pad.
// Latency: 34 snes ticks + 2 clocks from request to sample_valid.
// Backpressure: requests during a scan collapse into one pending rescan.
module snes_pad_poller
  import snes_pad_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int CLOCK_FREQ_HZ = 18181818,
  parameter int POLL_HZ       = 60,
  parameter int HALF_US       = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  snes_pad_poller_if.master bus
);

  localparam int TICK_DIV = calc_tick_div(longint'(CLOCK_FREQ_HZ), longint'(HALF_US));
  localparam int POLL_DIV = calc_poll_div(longint'(CLOCK_FREQ_HZ), longint'(POLL_HZ));
  localparam int POLL_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LAT_W    = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
  localparam int BIT_W    = $clog2(PAD_W);

  state_t              r_state, w_state_nxt;
  logic [POLL_W-1:0]   r_poll_cnt;
  logic                w_poll_wrap;
  logic                r_pend;
  logic                w_req, w_start;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic                w_tick, w_tick_clr;
  logic                w_shift, w_commit;
  logic [NUM_PADS-1:0] w_diff;
  logic                r_chg;
  logic                r_irq;
  logic                w_sclk, w_latch, w_busy, w_valid;

  // The prescaler only runs during an active scan so every phase starts aligned.
  assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_DONE);

  snes_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_tick_clr),
    .o_tick  (w_tick)
  );

  assign w_poll_wrap = (r_poll_cnt == POLL_W'(POLL_DIV - 1));
  assign w_req       = bus.poll_now | w_poll_wrap;
  assign w_start     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && r_pend;
  assign w_shift     = (r_state == ST_CLK_LOW) && w_tick;
  assign w_commit    = (r_state == ST_CLK_HIGH) && w_tick && (r_bit == BIT_W'(PAD_W - 1));

  // Free-running poll timer and the single pending-request flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_poll_cnt <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
      r_pend     <= w_req | (r_pend & ~w_start);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and Moore outputs of the scan sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_sclk      = 1'b1;
    w_latch     = 1'b0;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend) w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_latch = 1'b1;
        w_busy  = 1'b1;
        if (w_tick && (r_lat_cnt == LAT_W'(LATCH_TICKS - 1))) w_state_nxt = ST_CLK_LOW;
      end
      ST_CLK_LOW: begin
        w_sclk = 1'b0;
        w_busy = 1'b1;
        if (w_tick) w_state_nxt = ST_CLK_HIGH;
      end
      ST_CLK_HIGH: begin
        w_busy = 1'b1;
        if (w_tick) w_state_nxt = (r_bit == BIT_W'(PAD_W - 1)) ? ST_DONE : ST_CLK_LOW;
      end
      ST_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = r_pend ? ST_LATCH : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch tick counter, bit index, and change flag captured with the new words.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_lat_cnt <= '0;
      r_bit     <= '0;
      r_chg     <= 1'b0;
    end else begin
      if (r_state != ST_LATCH) r_lat_cnt <= '0;
      else if (w_tick)         r_lat_cnt <= r_lat_cnt + 1'b1;

      if (r_state == ST_LATCH) r_bit <= '0;
      else if ((r_state == ST_CLK_HIGH) && w_tick && (r_bit != BIT_W'(PAD_W - 1)))
        r_bit <= r_bit + 1'b1;

      if (w_commit) r_chg <= |(w_diff & bus.irq_mask);
    end
  end

  for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
    logic [PAD_W-1:0] r_shadow;
    logic [PAD_W-1:0] r_joy;

    assign w_diff[gp]                    = (r_shadow != r_joy);
    assign bus.joy_data[gp*PAD_W +: PAD_W] = r_joy;

    // Shift this pad's line into its shadow; publish all pads together.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_shadow <= '1;
        r_joy    <= '1;
      end else begin
        if (w_shift)  r_shadow[r_bit] <= bus.pad_data[gp];
        if (w_commit) r_joy           <= r_shadow;
      end
    end
  end

  // Sticky change interrupt; a new change in DONE beats a simultaneous ack.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else if ((r_state == ST_DONE) && r_chg) begin
      r_irq <= 1'b1;
    end else if (bus.irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign bus.snes_clock   = w_sclk;
  assign bus.snes_latch   = w_latch;
  assign bus.busy         = w_busy;
  assign bus.sample_valid = w_valid;
  assign bus.irq          = r_irq;

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench: TICK_DIV=6, POLL_DIV=1000, two emulated SNES pads.
// Latency: n/a.
// Backpressure: n/a.
module tb_snes_pad_poller;

  localparam int NP = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  int          cyc = 0, n_lrise = 0, t_lrise = 0, n_bfall = 0, n_valid = 0, t_valid = 0;
  int          n_lat_hi = 0, n_clk_lo = 0, n_clk_fall = 0;
  logic        p_latch = 1'b0, p_busy = 1'b0, p_sclk = 1'b1;
  logic [15:0] word0 = 16'hFFFF, word1 = 16'hFFFF;
  int          pad_bit = 0;
  int          t0, r0, a0, a1, a2;

  always #5 clock = ~clock;

  snes_pad_poller_if #(.NUM_PADS(NP)) bus ();

  snes_pad_poller #(
    .NUM_PADS      (NP),
    .CLOCK_FREQ_HZ (1_000_000),
    .POLL_HZ       (1000),
    .HALF_US       (6)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Pad emulation: latch reloads bit 0, each rising snes_clock advances.
  always @(posedge bus.snes_clock or posedge bus.snes_latch) begin
    if (bus.snes_latch) pad_bit <= 0;
    else                pad_bit <= pad_bit + 1;
  end
  assign bus.pad_data = {(pad_bit < 16) ? word1[pad_bit[3:0]] : 1'b1,
                         (pad_bit < 16) ? word0[pad_bit[3:0]] : 1'b1};

  // Event monitor sampled on the falling edge; cyc labels each falling edge.
  always @(negedge clock) begin
    cyc     <= cyc + 1;
    p_latch <= bus.snes_latch;
    p_busy  <= bus.busy;
    p_sclk  <= bus.snes_clock;
    if (bus.snes_latch && !p_latch) begin
      n_lrise <= n_lrise + 1;
      t_lrise <= cyc + 1;
    end
    if (!bus.busy && p_busy)         n_bfall    <= n_bfall + 1;
    if (bus.sample_valid) begin
      n_valid <= n_valid + 1;
      t_valid <= cyc + 1;
    end
    if (bus.snes_latch)              n_lat_hi   <= n_lat_hi + 1;
    if (!bus.snes_clock)             n_clk_lo   <= n_clk_lo + 1;
    if (p_sclk && !bus.snes_clock)   n_clk_fall <= n_clk_fall + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.poll_now = 1'b0;
    bus.irq_ack  = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  task automatic start_poll();
    bus.poll_now = 1'b1;
    t0 = cyc;
    step(1);
    bus.poll_now = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.sample_valid && n < 400) begin
      step(1);
      n++;
    end
    chk(tag, 32'(bus.sample_valid), 32'd1);
  endtask

  initial begin
    bus.poll_now = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.irq_mask = 2'b00;

    // Reset values.
    step(3);
    chk("rst_sclk",  32'(bus.snes_clock),   32'd1);
    chk("rst_latch", 32'(bus.snes_latch),   32'd0);
    chk("rst_busy",  32'(bus.busy),         32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_irq",   32'(bus.irq),          32'd0);
    chk("rst_joy",   bus.joy_data,          32'hFFFF_FFFF);

    // Single scan: phase lengths and result word.
    do_reset();
    word0 = 16'hA5F0;
    word1 = 16'h0001;
    step(4);
    a0 = n_lat_hi; a1 = n_clk_lo; a2 = n_clk_fall;
    start_poll();
    wait_valid("s1_valid");
    chk("s1_valid_lat", 32'(t_valid - t0),      32'd206);
    chk("s1_latch_lat", 32'(t_lrise - t0),      32'd2);
    chk("s1_latch_len", 32'(n_lat_hi - a0),     32'd12);
    chk("s1_clk_low",   32'(n_clk_lo - a1),     32'd96);
    chk("s1_clk_falls", 32'(n_clk_fall - a2),   32'd16);
    chk("s1_joy",       bus.joy_data,           32'h0001_A5F0);
    chk("s1_busy_done", 32'(bus.busy),          32'd0);
    step(1);
    chk("s1_valid_1cyc", 32'(bus.sample_valid), 32'd0);
    chk("s1_sclk_idle",  32'(bus.snes_clock),   32'd1);

    // Request at bit 5 of a running scan: back-to-back second scan.
    do_reset();
    word0 = 16'h1234;
    word1 = 16'h5678;
    step(4);
    a0 = n_lrise;
    start_poll();
    step(74);
    bus.poll_now = 1'b1;
    step(1);
    bus.poll_now = 1'b0;
    wait_valid("s2_valid1");
    chk("s2_valid1_lat", 32'(t_valid - t0),      32'd206);
    chk("s2_joy",        bus.joy_data,           32'h5678_1234);
    step(1);
    chk("s2_relatch",    32'(bus.snes_latch),    32'd1);
    wait_valid("s2_valid2");
    chk("s2_valid2_lat", 32'(t_valid - t0),      32'd411);
    step(300);
    chk("s2_scans",      32'(n_lrise - a0),      32'd2);

    // Reset at bit 9 aborts the scan.
    do_reset();
    word0 = 16'h0F0F;
    word1 = 16'hF0F0;
    step(4);
    start_poll();
    step(124);
    reset_n = 1'b0;
    step(1);
    chk("s3_sclk",  32'(bus.snes_clock), 32'd1);
    chk("s3_busy",  32'(bus.busy),       32'd0);
    chk("s3_latch", 32'(bus.snes_latch), 32'd0);
    chk("s3_joy",   bus.joy_data,        32'hFFFF_FFFF);
    reset_n = 1'b1;
    a0 = n_valid;
    step(250);
    chk("s3_no_valid", 32'(n_valid - a0), 32'd0);
    chk("s3_joy_kept", bus.joy_data,      32'hFFFF_FFFF);

    // Change interrupt with pad 0 enabled only.
    do_reset();
    bus.irq_mask = 2'b01;
    word0 = 16'hFFFF;
    word1 = 16'h1234;
    step(2);
    start_poll();
    wait_valid("s4_valid_a");
    step(2);
    chk("s4_joy_a",        bus.joy_data,   32'h1234_FFFF);
    chk("s4_irq_masked",   32'(bus.irq),   32'd0);
    word0 = 16'h00FF;
    start_poll();
    wait_valid("s4_valid_b");
    step(1);
    chk("s4_irq_set",      32'(bus.irq),   32'd1);
    word0 = 16'h0F0F;
    start_poll();
    wait_valid("s4_valid_c");
    bus.irq_ack = 1'b1;
    step(1);
    bus.irq_ack = 1'b0;
    chk("s4_set_beats_ack", 32'(bus.irq),  32'd1);
    step(2);
    bus.irq_ack = 1'b1;
    step(1);
    bus.irq_ack = 1'b0;
    chk("s4_ack_clears",   32'(bus.irq),   32'd0);
    bus.irq_mask = 2'b11;
    step(3);
    chk("s4_mask_no_set",  32'(bus.irq),   32'd0);
    bus.irq_mask = 2'b01;
    word1 = 16'h4321;
    start_poll();
    wait_valid("s4_valid_d");
    step(2);
    chk("s4_joy_d",        bus.joy_data,   32'h4321_0F0F);
    chk("s4_irq_pad1",     32'(bus.irq),   32'd0);

    // poll_now coinciding with the timer wrap gives one scan.
    do_reset();
    r0 = cyc;
    step(999);
    a0 = n_lrise; a1 = n_bfall; a2 = n_valid;
    start_poll();
    step(500);
    chk("s5_scans",      32'(n_lrise - a0), 32'd1);
    chk("s5_busy_falls", 32'(n_bfall - a1), 32'd1);
    chk("s5_valids",     32'(n_valid - a2), 32'd1);
    chk("s5_latch_at",   32'(t_lrise - r0), 32'd1001);

    // Free-running poll: requests at clocks 1000/2000/3000, latch one clock later.
    do_reset();
    a0 = n_lrise;
    step(1000);
    chk("s6_before_1",  32'(n_lrise - a0), 32'd0);
    step(1);
    chk("s6_scan_1",    32'(n_lrise - a0), 32'd1);
    step(999);
    chk("s6_before_2",  32'(n_lrise - a0), 32'd1);
    step(1);
    chk("s6_scan_2",    32'(n_lrise - a0), 32'd2);
    step(999);
    chk("s6_before_3",  32'(n_lrise - a0), 32'd2);
    step(1);
    chk("s6_scan_3",    32'(n_lrise - a0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
